// File: rtl/envelope_detector_pkg.sv
// Shared definitions for the envelope detector: FSM encoding, sample width
// and the beta shift amounts of the alpha-max-beta-min magnitude estimate.
package envelope_detector_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MAIN_OPP = 2'd1,
        DRAIN    = 2'd2,
        DONE     = 2'd3
    } state_t;

    localparam int ENV_BASE_WIDTH = 18;
    localparam int ENV_WIDTH      = ENV_BASE_WIDTH * 3;

    // beta = 1/4 + 1/8 = 3/8, realised as two right shifts
    localparam int BETA_SHIFT_LO = 2;
    localparam int BETA_SHIFT_HI = 3;

endpackage

// File: rtl/envelope_detector_mag.sv
// Three-stage magnitude estimator: |Re|,|Im| -> max/min -> max + 3/8*min.
// A valid bit and the sample index ride alongside the data through every stage.
module mag_approx_pipe
    import envelope_detector_pkg::*;
#(
    parameter int DATA_W  = ENV_WIDTH,
    parameter int INDEX_W = 16
) (
    input  logic                     clock,
    input  logic                     resetN,
    input  logic                     i_valid,
    input  logic signed [DATA_W-1:0] i_re,
    input  logic signed [DATA_W-1:0] i_im,
    input  logic [INDEX_W-1:0]       i_idx,
    output logic                     o_valid,
    output logic [DATA_W-1:0]        o_mag,
    output logic [INDEX_W-1:0]       o_idx,
    output logic                     o_busy
);

    // Unsigned result is one bit wider in range than the signed input, so the
    // most negative value maps to 2^(DATA_W-1) exactly.
    function automatic logic [DATA_W-1:0] abs_u(input logic signed [DATA_W-1:0] x);
        logic [DATA_W-1:0] u;
        u = x;
        return x[DATA_W-1] ? -u : u;
    endfunction

    function automatic logic [DATA_W-1:0] amax_bmin(input logic [DATA_W-1:0] mx,
                                                    input logic [DATA_W-1:0] mn);
        return mx + (mn >> BETA_SHIFT_LO) + (mn >> BETA_SHIFT_HI);
    endfunction

    logic [DATA_W-1:0]  r_a_p0;
    logic [DATA_W-1:0]  r_b_p0;
    logic [INDEX_W-1:0] r_idx_p0;
    logic               r_vld_p0;
    logic [DATA_W-1:0]  r_mx_p1;
    logic [DATA_W-1:0]  r_mn_p1;
    logic [INDEX_W-1:0] r_idx_p1;
    logic               r_vld_p1;
    logic [DATA_W-1:0]  r_mag_p2;
    logic [INDEX_W-1:0] r_idx_p2;
    logic               r_vld_p2;

    logic [DATA_W-1:0]  w_abs_re;
    logic [DATA_W-1:0]  w_abs_im;
    logic               w_a_ge_b;

    assign w_abs_re = abs_u(i_re);
    assign w_abs_im = abs_u(i_im);
    assign w_a_ge_b = (r_a_p0 >= r_b_p0);

    // Valid chain and the output magnitude; the output holds between samples.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_vld_p0 <= 1'b0;
            r_vld_p1 <= 1'b0;
            r_vld_p2 <= 1'b0;
            r_mag_p2 <= '0;
        end else begin
            r_vld_p0 <= i_valid;
            r_vld_p1 <= r_vld_p0;
            r_vld_p2 <= r_vld_p1;
            // p1 -> p2: alpha-max-beta-min sum
            if (r_vld_p1) begin
                r_mag_p2 <= amax_bmin(r_mx_p1, r_mn_p1);
            end
        end
    end

    always_ff @(posedge clock) begin
        // input -> p0: absolute values
        if (i_valid) begin
            r_a_p0   <= w_abs_re;
            r_b_p0   <= w_abs_im;
            r_idx_p0 <= i_idx;
        end
        // p0 -> p1: sort into max/min
        if (r_vld_p0) begin
            r_mx_p1  <= w_a_ge_b ? r_a_p0 : r_b_p0;
            r_mn_p1  <= w_a_ge_b ? r_b_p0 : r_a_p0;
            r_idx_p1 <= r_idx_p0;
        end
        if (r_vld_p1) begin
            r_idx_p2 <= r_idx_p1;
        end
    end

    assign o_valid = r_vld_p2;
    assign o_mag   = r_mag_p2;
    assign o_idx   = r_idx_p2;
    assign o_busy  = r_vld_p0 | r_vld_p1 | r_vld_p2;

endmodule

// File: rtl/envelope_detector.sv
// Envelope detector: frames the analytic-signal stream, estimates magnitude
// per sample and tracks the first index of the per-frame peak envelope.
module envelope_detector
    import envelope_detector_pkg::*;
#(
    parameter int DATA_WIDTH  = ENV_BASE_WIDTH,
    parameter int INDEX_WIDTH = 16
) (
    input  logic                         clock,
    input  logic                         resetN,
    input  logic                         enable,
    input  logic                         stopDataInFlag,
    input  logic                         dataInValid,
    input  logic signed [DATA_WIDTH*3-1:0] dataInRe,
    input  logic signed [DATA_WIDTH*3-1:0] dataInIm,
    output logic [DATA_WIDTH*3-1:0]      dataOut,
    output logic                         dataOutValid,
    output logic [DATA_WIDTH*3-1:0]      peakValue,
    output logic [INDEX_WIDTH-1:0]       peakIndex,
    output logic                         frameDone
);

    localparam int W = DATA_WIDTH * 3;
    localparam logic [INDEX_WIDTH-1:0] IDX_MAX = '1;

    state_t                 r_state;
    logic                   r_frame_done;
    logic [INDEX_WIDTH-1:0] r_idx_cnt;
    logic [W-1:0]           r_peak_value;
    logic [INDEX_WIDTH-1:0] r_peak_index;

    logic                   w_accept;
    logic                   w_frame_start;
    logic                   w_pipe_vld;
    logic                   w_pipe_busy;
    logic [W-1:0]           w_pipe_mag;
    logic [INDEX_WIDTH-1:0] w_pipe_idx;

    // Stop takes priority: a sample arriving with stop is dropped.
    assign w_accept      = (r_state == MAIN_OPP) && dataInValid && !stopDataInFlag;
    assign w_frame_start = (r_state == IDLE) && enable;

    mag_approx_pipe #(
        .DATA_W  (W),
        .INDEX_W (INDEX_WIDTH)
    ) u_mag (
        .clock   (clock),
        .resetN  (resetN),
        .i_valid (w_accept),
        .i_re    (dataInRe),
        .i_im    (dataInIm),
        .i_idx   (r_idx_cnt),
        .o_valid (w_pipe_vld),
        .o_mag   (w_pipe_mag),
        .o_idx   (w_pipe_idx),
        .o_busy  (w_pipe_busy)
    );

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_state      <= IDLE;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (enable) begin
                        r_state <= MAIN_OPP;
                    end
                end
                MAIN_OPP: begin
                    if (stopDataInFlag) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Peak registers settle on the edge that empties the pipe,
                    // so they are final by the DONE cycle.
                    if (!w_pipe_busy) begin
                        r_state      <= DONE;
                        r_frame_done <= 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_idx_cnt    <= '0;
            r_peak_value <= '0;
            r_peak_index <= '0;
        end else if (w_frame_start) begin
            r_idx_cnt    <= '0;
            r_peak_value <= '0;
            r_peak_index <= '0;
        end else begin
            if (w_accept && (r_idx_cnt != IDX_MAX)) begin
                r_idx_cnt <= r_idx_cnt + INDEX_WIDTH'(1);
            end
            // Strictly greater so that ties keep the earlier index.
            if (w_pipe_vld && (w_pipe_mag > r_peak_value)) begin
                r_peak_value <= w_pipe_mag;
                r_peak_index <= w_pipe_idx;
            end
        end
    end

    assign dataOut      = w_pipe_mag;
    assign dataOutValid = w_pipe_vld;
    assign peakValue    = r_peak_value;
    assign peakIndex    = r_peak_index;
    assign frameDone    = r_frame_done;

endmodule

// File: tb/tb_envelope_detector.sv
// Directed and randomized bench for envelope_detector with a scoreboard
// built from the magnitude formula and a per-frame peak model.
module tb_envelope_detector;

    localparam int DW = 18;
    localparam int IW = 16;
    localparam int W  = DW * 3;

    localparam longint MOST_NEG = -64'sd9007199254740992;
    localparam longint MOST_POS = 64'sd9007199254740991;

    logic                clock = 1'b0;
    logic                resetN;
    logic                enable;
    logic                stopDataInFlag;
    logic                dataInValid;
    logic signed [W-1:0] dataInRe;
    logic signed [W-1:0] dataInIm;
    logic [W-1:0]        dataOut;
    logic                dataOutValid;
    logic [W-1:0]        peakValue;
    logic [IW-1:0]       peakIndex;
    logic                frameDone;

    envelope_detector #(
        .DATA_WIDTH  (DW),
        .INDEX_WIDTH (IW)
    ) dut (
        .clock          (clock),
        .resetN         (resetN),
        .enable         (enable),
        .stopDataInFlag (stopDataInFlag),
        .dataInValid    (dataInValid),
        .dataInRe       (dataInRe),
        .dataInIm       (dataInIm),
        .dataOut        (dataOut),
        .dataOutValid   (dataOutValid),
        .peakValue      (peakValue),
        .peakIndex      (peakIndex),
        .frameDone      (frameDone)
    );

    always #5 clock = ~clock;

    typedef struct {
        longint mag;
        int     due;
    } exp_t;

    exp_t   q[$];
    int     n_tests = 0;
    int     n_fail  = 0;
    int     cyc     = 0;
    bit     in_frame = 0;
    bit     done_allowed = 0;
    longint last_mag = 0;
    longint pk_val = 0;
    int     pk_idx = 0;
    int     n_acc = 0;

    function automatic longint ref_mag(input longint re, input longint im);
        longint a, b, mx, mn;
        a  = (re < 0) ? -re : re;
        b  = (im < 0) ? -im : im;
        mx = (a > b) ? a : b;
        mn = (a > b) ? b : a;
        return mx + mn / 4 + mn / 8;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        exp_t   e;
        logic   exp_v;
        if (in_frame && dataInValid && !stopDataInFlag) begin
            e.mag = ref_mag(longint'(dataInRe), longint'(dataInIm));
            e.due = cyc + 3;
            q.push_back(e);
            if (e.mag > pk_val) begin
                pk_val = e.mag;
                pk_idx = n_acc;
            end
            if (n_acc < (1 << IW) - 1) n_acc++;
        end
        if (in_frame && stopDataInFlag) in_frame = 0;
        @(posedge clock);
        #1;
        cyc++;
        exp_v = 1'b0;
        if (q.size() > 0 && q[0].due == cyc) begin
            exp_v    = 1'b1;
            last_mag = q[0].mag;
            void'(q.pop_front());
        end
        check("out_valid", 64'(dataOutValid), 64'(exp_v));
        check("out_data", 64'(dataOut), last_mag);
        if (!done_allowed) check("no_done", 64'(frameDone), 64'd0);
    endtask

    task automatic drive(input bit v, input longint re, input longint im, input bit stop);
        dataInValid    = v;
        dataInRe       = re[W-1:0];
        dataInIm       = im[W-1:0];
        stopDataInFlag = stop;
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 0, 0, 1'b0);
    endtask

    task automatic start_frame(input string tag);
        enable = 1'b1;
        drive(1'b0, 0, 0, 1'b0);
        enable   = 1'b0;
        in_frame = 1;
        n_acc    = 0;
        pk_val   = 0;
        pk_idx   = 0;
        check({tag, "_pk_clr"}, 64'(peakValue), 64'd0);
        check({tag, "_pi_clr"}, 64'(peakIndex), 64'd0);
    endtask

    task automatic stop_frame(input string tag, input bit v, input longint re, input longint im);
        int s;
        bit seen;
        s = cyc;
        seen = 0;
        done_allowed = 1;
        drive(v, re, im, 1'b1);
        dataInValid    = 1'b0;
        stopDataInFlag = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (frameDone === 1'b1) begin
                seen = 1;
                break;
            end
            tick();
        end
        if (!seen && frameDone === 1'b1) seen = 1;
        check({tag, "_done_seen"}, 64'(seen), 64'd1);
        check({tag, "_done_lat_le4"}, 64'((cyc - s) <= 4), 64'd1);
        check({tag, "_drained"}, 64'(q.size()), 64'd0);
        check({tag, "_peak_val"}, 64'(peakValue), pk_val);
        check({tag, "_peak_idx"}, 64'(peakIndex), 64'(pk_idx));
        tick();
        check({tag, "_done_1cyc"}, 64'(frameDone), 64'd0);
        check({tag, "_peak_hold"}, 64'(peakValue), pk_val);
        done_allowed = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        longint re, im;
        bit     v;

        resetN = 1'b0;
        enable = 1'b0;
        stopDataInFlag = 1'b0;
        dataInValid = 1'b0;
        dataInRe = '0;
        dataInIm = '0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_dout", 64'(dataOut), 64'd0);
        check("rst_dvld", 64'(dataOutValid), 64'd0);
        check("rst_pval", 64'(peakValue), 64'd0);
        check("rst_pidx", 64'(peakIndex), 64'd0);
        check("rst_done", 64'(frameDone), 64'd0);
        @(negedge clock);
        resetN = 1'b1;
        idle(2);

        // Basic magnitude, latency, and the most negative input.
        start_frame("t1");
        drive(1'b1, 3000, 4000, 1'b0);
        idle(2);
        check("t1_mag", 64'(dataOut), 64'd5125);
        check("t1_vld", 64'(dataOutValid), 64'd1);
        idle(1);
        check("t1_vld_pulse", 64'(dataOutValid), 64'd0);
        drive(1'b1, -8, 0, 1'b0);
        drive(1'b1, MOST_NEG, MOST_NEG, 1'b0);
        idle(1);
        check("t2_mag_a", 64'(dataOut), 64'd8);
        idle(1);
        check("t2_mag_b", 64'(dataOut), 64'd12384898975268864);
        check("t2_vld_b", 64'(dataOutValid), 64'd1);
        stop_frame("t2", 1'b0, 0, 0);

        // Peak with a tie: first index wins.
        start_frame("t3");
        drive(1'b1, 5, 0, 1'b0);
        drive(1'b1, 20, 0, 1'b0);
        drive(1'b1, 0, 20, 1'b0);
        drive(1'b1, -7, 0, 1'b0);
        stop_frame("t3", 1'b0, 0, 0);
        check("t3_peak_20", 64'(peakValue), 64'd20);
        check("t3_idx_1", 64'(peakIndex), 64'd1);

        // Stop together with a valid sample drops that sample.
        start_frame("t4");
        drive(1'b1, 50, 0, 1'b0);
        drive(1'b1, 60, 0, 1'b0);
        stop_frame("t4", 1'b1, 100, 0);
        check("t4_peak_60", 64'(peakValue), 64'd60);

        // Asynchronous reset with samples in flight.
        start_frame("t5");
        drive(1'b1, 30, 40, 1'b0);
        drive(1'b1, 70, 0, 1'b0);
        #2;
        resetN = 1'b0;
        #1;
        check("t5_rst_dout", 64'(dataOut), 64'd0);
        check("t5_rst_dvld", 64'(dataOutValid), 64'd0);
        check("t5_rst_pval", 64'(peakValue), 64'd0);
        check("t5_rst_pidx", 64'(peakIndex), 64'd0);
        check("t5_rst_done", 64'(frameDone), 64'd0);
        q.delete();
        in_frame = 0;
        last_mag = 0;
        dataInValid = 1'b0;
        dataInRe = '0;
        dataInIm = '0;
        @(negedge clock);
        resetN = 1'b1;
        idle(5);
        start_frame("t5b");
        drive(1'b1, 4, 0, 1'b0);
        drive(1'b1, 9, 0, 1'b0);
        stop_frame("t5b", 1'b0, 0, 0);
        check("t5b_idx_1", 64'(peakIndex), 64'd1);

        // Valid gaps are not counted in the index.
        start_frame("t6");
        drive(1'b1, 10, 0, 1'b0);
        drive(1'b0, 99, 99, 1'b0);
        drive(1'b1, 11, 0, 1'b0);
        drive(1'b1, 0, -12, 1'b0);
        idle(3);
        stop_frame("t6", 1'b0, 0, 0);
        check("t6_idx_2", 64'(peakIndex), 64'd2);

        // Randomized frame, including the extremes of the input range.
        start_frame("t7");
        for (int i = 0; i < 60; i++) begin
            v  = ($urandom_range(0, 3) != 0);
            re = longint'({$urandom(), $urandom()}) >>> 10;
            im = longint'({$urandom(), $urandom()}) >>> 10;
            if (i % 15 == 7) re = MOST_NEG;
            if (i % 15 == 11) im = MOST_POS;
            if (i % 20 == 3) re = -re >>> 20;
            drive(v, re, im, 1'b0);
        end
        stop_frame("t7", 1'($urandom_range(0, 1)), 12345, -6789);

        idle(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
